// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register driving a combinational instruction
// memory, with a 2-entry {instr, pc} queue that decouples fetch from decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8
);

    // Handshake: an entry moves to decode on every cycle where id_valid && id_ready.
    // While id_valid is high and id_ready is low, id_instr/id_pc/id_pc8 are held.
    // A redirect flushes the queue; an entry accepted in that same cycle is not re-presented.

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;
    logic [31:0] q_instr [2];
    logic [31:0] q_pc    [2];
    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic        deq;
    logic        enq;
    logic        unused_redirect_low;

    assign pc_plus4         = pc + 32'd4;
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_low = ^redirect_pc[1:0];

    assign imem_a   = pc;
    assign id_valid = (count != 2'd0);
    assign id_instr = q_instr[head];
    assign id_pc    = q_pc[head];
    assign id_pc8   = q_pc[head] + 32'd8;

    assign deq = id_valid && id_ready;
    // A full queue can still accept a new word when the head leaves this cycle.
    assign enq = !redirect_valid && ((count != 2'd2) || deq);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (redirect_valid) begin
            pc    <= redirect_aligned;
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (enq) begin
                q_instr[tail] <= imem_rd;
                q_pc[tail]    <= pc;
                tail          <= ~tail;
                pc            <= pc_plus4;
            end
            if (deq) begin
                head <= ~head;
            end
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-level reference model checked every cycle, plus
// directed literal checks for streaming, backpressure, redirect, reset and PC wrap.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;

    logic [31:0] w_imem_a;
    logic [31:0] w_imem_rd;
    logic        w_id_valid;
    logic [31:0] w_id_instr;
    logic [31:0] w_id_pc;
    logic [31:0] w_id_pc8;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];
    logic [31:0] model_pc;
    bit          model_ok = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00000000: mem_word = 32'hE3A00005;
            32'h00000004: mem_word = 32'hE3A01008;
            default:      mem_word = a ^ 32'hA5A50000;
        endcase
    endfunction

    assign imem_rd   = mem_word(imem_a);
    assign w_imem_rd = mem_word(w_imem_a);
    assign w_redirect_valid = 1'b0;
    assign w_redirect_pc    = 32'h00000000;

    fetch_stage dut (
        .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc8(id_pc8)
    );

    fetch_stage #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
        .clk(clk), .reset(reset), .imem_a(w_imem_a), .imem_rd(w_imem_rd),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .id_ready(id_ready), .id_valid(w_id_valid), .id_instr(w_id_instr),
        .id_pc(w_id_pc), .id_pc8(w_id_pc8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // reference model: a queue of {instr, pc} plus the fetch address
    initial begin
        logic do_deq;
        logic room;
        logic [31:0] a;
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_q.delete();
                model_pc = 32'h00000000;
                model_ok = 1;
            end else if (model_ok) begin
                if (redirect_valid) begin
                    exp_q.delete();
                    a = redirect_pc;
                    model_pc = a & 32'hFFFFFFFC;
                end else begin
                    do_deq = (exp_q.size() > 0) && id_ready;
                    room   = (exp_q.size() < 2) || do_deq;
                    if (do_deq) void'(exp_q.pop_front());
                    if (room) begin
                        exp_q.push_back({mem_word(model_pc), model_pc});
                        model_pc = model_pc + 32'd4;
                    end
                end
            end
        end
    end

    // scoreboard compare, every cycle once the model is defined
    initial begin
        logic [63:0] h;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                chk("sb_id_valid", {31'd0, id_valid}, {31'd0, exp_q.size() != 0});
                chk("sb_imem_a", imem_a, model_pc);
                if (exp_q.size() != 0) begin
                    h = exp_q[0];
                    chk("sb_id_instr", id_instr, h[63:32]);
                    chk("sb_id_pc", id_pc, h[31:0]);
                    chk("sb_id_pc8", id_pc8, h[31:0] + 32'd8);
                end
            end
        end
    end

    // directed stimulus with literal expectations
    initial begin
        logic [23:0] rdy_pat;
        reset = 1'b1;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) next_cycle();

        // streaming
        reset = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_imem_a", imem_a, 32'h00000000);
        chk("wrap_rst_imem_a", w_imem_a, 32'hFFFFFFFC);
        chk("wrap_rst_id_valid", {31'd0, w_id_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("stream0_valid", {31'd0, id_valid}, 32'd1);
        chk("stream0_instr", id_instr, 32'hE3A00005);
        chk("stream0_pc", id_pc, 32'h00000000);
        chk("stream0_pc8", id_pc8, 32'h00000008);
        chk("wrap0_pc", w_id_pc, 32'hFFFFFFFC);
        chk("wrap0_pc8", w_id_pc8, 32'h00000004);
        chk("wrap0_imem_a", w_imem_a, 32'h00000000);
        next_cycle();
        @(negedge clk);
        chk("stream1_instr", id_instr, 32'hE3A01008);
        chk("stream1_pc", id_pc, 32'h00000004);
        chk("wrap1_pc", w_id_pc, 32'h00000000);
        chk("wrap1_pc8", w_id_pc8, 32'h00000008);

        // backpressure
        reset = 1'b1;
        id_ready = 1'b0;
        next_cycle();
        reset = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        chk("bp_imem_a", imem_a, 32'h00000008);
        chk("bp_instr", id_instr, 32'hE3A00005);
        chk("bp_pc", id_pc, 32'h00000000);
        id_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("bp_w1_pc", id_pc, 32'h00000004);
        chk("simul_imem_a", imem_a, 32'h0000000C);
        next_cycle();
        @(negedge clk);
        chk("bp_w2_pc", id_pc, 32'h00000008);
        chk("bp_w2_instr", id_instr, 32'hA5A50008);

        // redirect while full, with a coincident dequeue
        id_ready = 1'b0;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h00000031;
        id_ready = 1'b1;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_bubble", {31'd0, id_valid}, 32'd0);
        chk("redir_imem_a", imem_a, 32'h00000030);
        next_cycle();
        @(negedge clk);
        chk("redir_valid", {31'd0, id_valid}, 32'd1);
        chk("redir_pc", id_pc, 32'h00000030);

        // reset mid-stream with a full queue at PC 0x20
        id_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h00000018;
        next_cycle();
        redirect_valid = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        chk("mid_imem_a", imem_a, 32'h00000020);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, id_valid}, 32'd0);
        chk("mid_rst_imem_a", imem_a, 32'h00000000);
        id_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("mid_rst_first_pc", id_pc, 32'h00000000);

        // mixed ready pattern with unaligned redirects, checked by the scoreboard
        rdy_pat = 24'b1011_0011_1000_1101_1110_0101;
        for (int i = 0; i < 24; i++) begin
            id_ready = rdy_pat[i];
            redirect_valid = (i == 10) || (i == 17);
            redirect_pc = 32'h00000100 + i * 4 + 2;
            next_cycle();
        end
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        repeat (4) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h00000000, giving the PC value loaded on reset.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The module SHALL have port imem_a, output, 32 bits, the byte address of the word to fetch, driven to the instruction memory.
REQ-005 The module SHALL have port imem_rd, input, 32 bits, the instruction word returned combinationally for imem_a in the same cycle.
REQ-006 The module SHALL have port redirect_valid, input, 1 bit, a taken-branch or exception redirect request.
REQ-007 The module SHALL have port redirect_pc, input, 32 bits, the redirect target address.
REQ-008 The module SHALL have port id_ready, input, 1 bit, asserted by decode when it accepts an instruction this cycle.
REQ-009 The module SHALL have port id_valid, output, 1 bit, asserted when id_instr, id_pc and id_pc8 hold a valid instruction.
REQ-010 The module SHALL have port id_instr, output, 32 bits, the instruction word at the head of the queue.
REQ-011 The module SHALL have port id_pc, output, 32 bits, the fetch address of id_instr.
REQ-012 The module SHALL have port id_pc8, output, 32 bits, equal to id_pc + 8, the architectural R15 read value.

Function
REQ-013 The module SHALL hold a 32-bit PC register and SHALL drive imem_a = PC combinationally.
REQ-014 The module SHALL hold a 2-entry FIFO of {instr, pc} pairs with a 2-bit count (0..2), head and tail pointers.
REQ-015 Dequeue SHALL occur in any cycle where id_valid && id_ready.
REQ-016 Enqueue SHALL occur in any cycle with redirect_valid = 0 and (count < 2 or a dequeue occurs); the entry written SHALL be {imem_rd, PC}, and PC SHALL advance to PC + 4.
REQ-017 When count = 2 and no dequeue occurs, PC and the FIFO SHALL hold their values (fetch stall); imem_a stays stable.
REQ-018 Simultaneous enqueue and dequeue SHALL leave count unchanged, including at count = 2 and count = 1.
REQ-019 When redirect_valid = 1, the FIFO SHALL be emptied (count = 0) and PC SHALL be loaded with {redirect_pc[31:2], 2'b00}; no enqueue occurs that cycle, and any coincident dequeue is accepted by decode but not re-presented.
REQ-020 The first instruction from the redirect target SHALL appear on id_valid/id_instr in the cycle after the redirect cycle (1-cycle bubble).
REQ-021 id_valid SHALL equal (count != 0); id_instr, id_pc and id_pc8 SHALL be driven from the head entry and SHALL remain stable while id_valid && !id_ready.
REQ-022 PC + 4 and id_pc + 8 SHALL be modulo 2^32; PC 32'hFFFFFFFC SHALL wrap to 32'h00000000.
REQ-023 Latency from a word appearing on imem_rd (with the FIFO empty) to id_valid SHALL be exactly 1 cycle.
REQ-024 Throughput SHALL be one instruction per cycle while id_ready stays high and no redirect occurs.

Reset
REQ-025 While reset = 1 at a clock edge, PC SHALL load RESET_PC, count, head and tail SHALL clear to 0, and redirect_valid and id_ready SHALL be ignored.
REQ-026 In the cycle after reset, id_valid SHALL be 0, imem_a SHALL equal RESET_PC, and id_instr/id_pc SHALL be don't-care.
REQ-027 Reset asserted mid-stream with a full FIFO SHALL discard both entries; no discarded entry SHALL ever be presented.

Verification
REQ-028 Streaming: imem word 0 = 32'hE3A00005 and word 1 = 32'hE3A01008, id_ready held at 1 after reset -> id_instr E3A00005/id_pc 0/id_pc8 8, then E3A01008/id_pc 4 on consecutive cycles.
REQ-029 Backpressure: id_ready = 0 for 4 cycles after reset -> count saturates at 2, PC holds at 8, id_instr stays at word 0; on id_ready = 1, words 0, 1, 2 follow with no gap or duplicate.
REQ-030 Redirect: redirect_valid = 1 with redirect_pc = 32'h00000031 while count = 2 -> next cycle id_valid = 0 and imem_a = 32'h30, following cycle id_pc = 32'h30.
REQ-031 Simultaneous: count = 2, id_ready = 1, no redirect -> one entry leaves, one enters, count stays 2, PC advances by 4.
REQ-032 Wrap: RESET_PC = 32'hFFFFFFFC -> first id_pc = 32'hFFFFFFFC with id_pc8 = 32'h00000004, second id_pc = 32'h00000000.
REQ-033 Reset mid-operation: reset pulsed for 1 cycle with count = 2 and PC = 32'h20 -> next cycle id_valid = 0, imem_a = RESET_PC.
